// File: rtl/npc_bpred.sv
// npc_bpred: next-PC prediction and resolution unit.
//
// IF side : a direct-mapped BTB with saturating direction counters turns
//           fetch_pc into pred_npc / pred_taken (purely combinational).
// EX side : resolves the real next PC for j/jal/jr/beq/bne/blez. It raises
//           redirect when that PC differs from the prediction carried down
//           the pipe. It also trains the BTB and counts branches and
//           mispredictions.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_pc              PC currently in IF
//   pred_npc, pred_taken  predicted next PC / prediction came from the BTB
//   ex_valid, ex_pc,      EX-stage instruction, its PC and PC+4
//   ex_pc1
//   ex_j .. ex_blez       decoded control type (one-hot or none)
//   ex_equ, ex_rf_a       operand equality, rs value (jr target, blez operand)
//   ex_ext, ex_index      branch byte offset, absolute jump target
//   ex_pred_npc           pred_npc that travelled with this instruction
//   redirect, redirect_pc misprediction flag and the correct next PC
//   correct_b             a conditional branch resolved taken
//   branch_cnt,           statistics counters (wrap)
//   mispred_cnt
module npc_bpred #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  pred_npc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_pc1,
    input  logic             ex_j,
    input  logic             ex_jal,
    input  logic             ex_jr,
    input  logic             ex_beq,
    input  logic             ex_bne,
    input  logic             ex_blez,
    input  logic             ex_equ,
    input  logic [XLEN-1:0]  ex_rf_a,
    input  logic [XLEN-1:0]  ex_ext,
    input  logic [XLEN-1:0]  ex_index,
    input  logic [XLEN-1:0]  ex_pred_npc,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             correct_b,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

    // Flattened read view of the per-entry registers held in g_btb.
    logic [BTB_ENTRIES-1:0]               valid_vec;
    logic [BTB_ENTRIES-1:0]               uncond_vec;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0]    tag_vec;
    logic [BTB_ENTRIES-1:0][XLEN-1:0]     target_vec;
    logic [BTB_ENTRIES-1:0][CTR_BITS-1:0] ctr_vec;

    // ---------------- IF: prediction ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx      = fetch_pc[IDX_W+1:2];
    assign f_tag      = fetch_pc[XLEN-1:IDX_W+2];
    assign f_hit      = valid_vec[f_idx] && (tag_vec[f_idx] == f_tag);
    assign pred_taken = f_hit && (uncond_vec[f_idx] || ctr_vec[f_idx][CTR_BITS-1]);
    assign pred_npc   = pred_taken ? target_vec[f_idx] : fetch_pc + XLEN'(4);

    // ---------------- EX: resolution ----------------
    logic            is_jump, is_branch, ctl;
    logic            blez_taken, br_taken;
    logic [XLEN-1:0] br_target, ctl_target, actual_npc;

    assign is_jump    = ex_j | ex_jal | ex_jr;
    assign is_branch  = ex_beq | ex_bne | ex_blez;
    assign ctl        = is_jump | is_branch;
    // Signed rf_a <= 0: negative or exactly zero.
    assign blez_taken = ex_rf_a[XLEN-1] || (ex_rf_a == '0);
    assign br_taken   = (ex_beq && ex_equ) || (ex_bne && !ex_equ) || (ex_blez && blez_taken);
    assign br_target  = ex_pc1 + ex_ext;
    // Target stored in the BTB is the taken target even when a branch
    // resolves not-taken, so hysteresis keeps predicting the right place.
    assign ctl_target = ex_jr ? ex_rf_a : ((ex_j | ex_jal) ? ex_index : br_target);
    assign actual_npc = ex_jr ? ex_rf_a :
                        (ex_j | ex_jal) ? ex_index :
                        br_taken ? br_target : ex_pc1;

    assign redirect    = ex_valid && (actual_npc != ex_pred_npc);
    assign redirect_pc = ex_valid ? actual_npc : '0;
    assign correct_b   = ex_valid && br_taken;

    // ---------------- EX: BTB training ----------------
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit, do_train, do_alloc, do_kill;
    logic [1:0]       unused_pc_bits;

    assign e_idx    = ex_pc[IDX_W+1:2];
    assign e_tag    = ex_pc[XLEN-1:IDX_W+2];
    assign e_hit    = valid_vec[e_idx] && (tag_vec[e_idx] == e_tag);
    assign do_train = ctl && e_hit;
    assign do_alloc = ctl && !e_hit && (is_jump || br_taken);
    // A non-control instruction hitting the BTB means the entry is stale.
    assign do_kill  = !ctl && e_hit;
    assign unused_pc_bits = ex_pc[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            logic                sel;
            logic                valid_reg, uncond_reg;
            logic [TAG_W-1:0]    tag_reg;
            logic [XLEN-1:0]     target_reg;
            logic [CTR_BITS-1:0] ctr_reg;

            assign sel = ex_valid && (e_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg  <= 1'b0;
                    uncond_reg <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= WEAK_NT;
                end else if (sel) begin
                    if (do_train) begin
                        target_reg <= ctl_target;
                        uncond_reg <= is_jump;
                        if (is_branch) begin
                            if (br_taken && ctr_reg != CTR_MAX)
                                ctr_reg <= ctr_reg + CTR_BITS'(1);
                            else if (!br_taken && ctr_reg != CTR_MIN)
                                ctr_reg <= ctr_reg - CTR_BITS'(1);
                        end
                    end else if (do_alloc) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= e_tag;
                        target_reg <= ctl_target;
                        uncond_reg <= is_jump;
                        ctr_reg    <= WEAK_T;
                    end else if (do_kill) begin
                        valid_reg  <= 1'b0;
                    end
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign uncond_vec[gi] = uncond_reg;
            assign tag_vec[gi]    = tag_reg;
            assign target_vec[gi] = target_reg;
            assign ctr_vec[gi]    = ctr_reg;
        end
    endgenerate

    // ---------------- statistics ----------------
    logic [CNT_W-1:0] branch_cnt_reg, mispred_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (ex_valid && ctl) branch_cnt_reg  <= branch_cnt_reg + CNT_W'(1);
            if (redirect)        mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
        end
    end

    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;
endmodule

// File: doc/npc_bpred.md
Name: npc_bpred

Overview:
- Parametrised next-PC unit for the pipelined CPU.
- Predicts the next fetch PC in IF using a direct-mapped branch target buffer (BTB) with saturating direction counters.
- Resolves the real next PC in EX for j/jal/jr/beq/bne/blez, raises a redirect on misprediction, trains the BTB and keeps branch/mispredict statistics.

Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, BTB depth; must be a power of 2 and >= 2. IDX_W = log2(BTB_ENTRIES).
- CTR_BITS, 2, width of each direction counter; must be >= 2.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  XLEN  PC currently in IF.
- pred_npc  out  XLEN  predicted next PC (combinational).
- pred_taken  out  1  prediction is a BTB redirect (combinational).
- ex_valid  in  1  EX holds a valid instruction this cycle.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_pc1  in  XLEN  ex_pc + 4.
- ex_j, ex_jal, ex_jr, ex_beq, ex_bne, ex_blez  in  1 each  decoded control type; at most one is set.
- ex_equ  in  1  register operands are equal.
- ex_rf_a  in  XLEN  rs value; the jr target and the blez operand.
- ex_ext  in  XLEN  pre-shifted branch byte offset.
- ex_index  in  XLEN  absolute j/jal target.
- ex_pred_npc  in  XLEN  pred_npc carried down the pipe with this instruction.
- redirect  out  1  misprediction; flush IF/ID and refetch.
- redirect_pc  out  XLEN  correct next PC.
- correct_b  out  1  a conditional branch resolved taken.
- branch_cnt  out  CNT_W  resolved control instructions.
- mispred_cnt  out  CNT_W  redirects raised.

Behaviour:
- BTB entry fields: valid, tag, target, uncond, ctr[CTR_BITS-1:0].
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2].
- Prediction (combinational):
  - hit = valid && tag match.
  - If hit && (uncond || ctr MSB set): pred_npc = target, pred_taken = 1.
  - Otherwise: pred_npc = fetch_pc + 4, pred_taken = 0.
- Resolution (combinational, active only when ex_valid):
  - ctl = any of the six type inputs.
  - blez taken when ex_rf_a <= 0 as a signed compare.
  - br_taken = (beq && equ) || (bne && !equ) || (blez && signed rf_a <= 0).
  - actual_npc priority: jr -> rf_a; j/jal -> index; br_taken -> pc1 + ext (modulo 2^XLEN); else pc1.
  - redirect = ex_valid && (actual_npc != ex_pred_npc). This also covers non-control instructions that hit a stale BTB entry.
  - redirect_pc = actual_npc.
  - correct_b = ex_valid && br_taken.
  - All three outputs are 0 when !ex_valid.
- BTB update (rising clk, when ex_valid):
  - ctl && tag hit: target <= actual target; uncond <= j|jal|jr. For conditional branches, ctr saturating +1 if taken, -1 if not taken. Never wraps past all-ones or zero.
  - ctl && miss && (jump, or branch taken): allocate the entry and overwrite any aliasing entry. Set valid, tag, target; uncond <= j|jal|jr; ctr <= weakly taken (MSB=1, rest 0).
  - ctl && miss && branch not taken: no allocation.
  - !ctl && hit (stale entry): invalidate that entry.
- Same-cycle read/write to the same index: the prediction uses the pre-update contents. No bypass.
- Statistics (rising clk, both wrap modulo 2^CNT_W):
  - branch_cnt += 1 when ex_valid && ctl.
  - mispred_cnt += 1 when redirect.
- Reset (asynchronous, any time including mid-update):
  - All valid <= 0; all ctr <= weakly not taken (MSB=0, rest 1); tag/target <= 0.
  - branch_cnt and mispred_cnt <= 0.
  - With all entries invalid, pred_npc = fetch_pc + 4 and pred_taken = 0. Combinational outputs follow the inputs immediately after reset.
- Storage: registers, not RAM, so reset clears every entry.

Test Plan:
- Reset, fetch_pc=0x100 -> pred_npc=0x104, pred_taken=0. Then resolve beq at 0x100 with equ=0, ex_pred_npc=0x104 -> redirect=0, branch_cnt=1, no allocation.
- beq at 0x100, equ=1, ext=0x20, ex_pc1=0x104, ex_pred_npc=0x104 -> redirect=1, redirect_pc=0x124, correct_b=1, mispred_cnt=1. Next cycle fetch_pc=0x100 -> pred_npc=0x124, pred_taken=1.
- Counter hysteresis on the same beq: two more taken resolutions saturate ctr at 11; one not-taken still predicts 0x124; a second not-taken gives pred_npc=0x104.
- jr at 0x200, rf_a=0x400, then again with rf_a=0x480 and ex_pred_npc=0x400 -> second resolution redirect=1, redirect_pc=0x480; BTB target becomes 0x480.
- blez with rf_a=0xFFFFFFFF (-1), ext=0x10, pc1=0x304 -> taken, redirect_pc=0x314. With rf_a=0x00000001 -> not taken, redirect_pc=0x304.
- Aliasing (BTB_ENTRIES=16): taken branch at 0x040, then j at 0x080 (same index, different tag) -> 0x040 no longer hits. Assert rst_n low mid-run -> all outputs return to reset values asynchronously, with no clock edge.
